// File: rtl/prc_pkg.sv
// prc_pkg: shared states, LCD command bytes, framebuffer geometry and default addresses
// Build option: PRC_COPY_CLEAR_EN adds the CLR_FB state (framebuffer cleared after each byte is copied).
package prc_pkg;
  localparam int FB_COLUMNS = 96;
  localparam int FB_PAGES = 8;
  localparam logic [7:0] PAGE_CMD = 8'hB0;
  localparam logic [7:0] COL_LO_CMD = 8'h00;
  localparam logic [7:0] COL_HI_CMD = 8'h10;
  localparam logic [23:0] DEF_FB_BASE = 24'h001000;
  localparam logic [23:0] DEF_LCD_CMD_ADDR = 24'h0020FE;
  localparam logic [23:0] DEF_LCD_DATA_ADDR = 24'h0020FF;
  typedef enum logic [3:0] {
    IDLE, WAIT_GRANT, CMD_PAGE, CMD_COL_LO, CMD_COL_HI, RD_FB, WR_LCD,
`ifdef PRC_COPY_CLEAR_EN
    CLR_FB,
`endif
    NEXT, DONE
  } state_t;
  function automatic logic [23:0] fb_offset(input logic [2:0] page, input logic [6:0] col);
    return 24'(page) * 24'(FB_COLUMNS) + 24'(col);
  endfunction
endpackage

// File: rtl/prc_bus_if.sv
// prc_bus_if: single-master bus between the copy engine and memory/LCD
// master: drives bus_request, address_out, data_out, bus_write, bus_read; samples bus_grant, data_in
// slave:  the mirror image
interface prc_bus_if;
  logic bus_request, bus_grant, bus_write, bus_read;
  logic [23:0] address_out;
  logic [7:0] data_out, data_in;
  modport master(output bus_request, bus_write, bus_read, address_out, data_out, input bus_grant, data_in);
  modport slave(input bus_request, bus_write, bus_read, address_out, data_out, output bus_grant, data_in);
endinterface

// File: rtl/prc_bus_cycle.sv
// prc_bus_cycle: two-cycle access sequencer (A: strobe high, B: strobe low, address/data held) with grant stall and read capture
// Ports: clk, reset_n; act/we/addr/wdata describe the pending access; grant gates cycle A;
// wr/rd/addr_o/wdata_o drive the bus; ack is high in cycle B; rdata holds the byte captured at the end of a read's cycle B.
module prc_bus_cycle (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        act,
  input  logic        we,
  input  logic        grant,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  rdata_in,
  output logic        wr,
  output logic        rd,
  output logic        ack,
  output logic [23:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic [7:0]  rdata
);
  logic ph, go;
  always_comb begin
    go = act && !ph && grant;
    wr = go && we;
    rd = go && !we;
    ack = ph;
    addr_o = act ? addr : '0;
    wdata_o = act && we ? wdata : '0;
  end
  // ph marks cycle B; a cycle A only happens with grant, so a stalled access simply retries next cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ph <= 1'b0;
      rdata <= '0;
    end else begin
      ph <= go;
      if (ph && !we) rdata <= rdata_in;
    end
endmodule

// File: rtl/prc_copy_engine.sv
// prc_copy_engine: copies a 96x64 page-major framebuffer to the LCD (page/column commands, then read/write per byte)
// Ports: clk, reset_n (async, active-low); start (one-cycle request); busy; done (one-cycle pulse); bus (prc_bus_if.master)
// Build option: PRC_COPY_CLEAR_EN writes 8'h00 back to each framebuffer byte after it reaches the LCD.
module prc_copy_engine
  import prc_pkg::*;
#(
  parameter logic [23:0] FB_BASE = DEF_FB_BASE,
  parameter logic [23:0] LCD_CMD_ADDR = DEF_LCD_CMD_ADDR,
  parameter logic [23:0] LCD_DATA_ADDR = DEF_LCD_DATA_ADDR
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  output logic done,
  prc_bus_if.master bus
);
  state_t state, nxt, after_data;
  logic [2:0] page;
  logic [6:0] col;
  logic act, we, ack, fb_acc, col_end, frame_end, adv;
  logic [23:0] addr;
  logic [7:0] wdata, rdata;
`ifdef PRC_COPY_CLEAR_EN
  localparam state_t LAST_DATA = CLR_FB;
  assign fb_acc = state == RD_FB || state == CLR_FB;
`else
  localparam state_t LAST_DATA = WR_LCD;
  assign fb_acc = state == RD_FB;
`endif
  assign col_end = col == 7'(FB_COLUMNS - 1);
  assign frame_end = col_end && page == 3'(FB_PAGES - 1);
  // the byte's last access advances the counters and jumps straight to the next access, so NEXT never costs a cycle
  assign after_data = frame_end ? DONE : col_end ? CMD_PAGE : RD_FB;
  assign adv = ack && state == LAST_DATA;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = start ? WAIT_GRANT : IDLE;
      WAIT_GRANT: nxt = bus.bus_grant ? CMD_PAGE : WAIT_GRANT;
      CMD_PAGE:   nxt = ack ? CMD_COL_LO : CMD_PAGE;
      CMD_COL_LO: nxt = ack ? CMD_COL_HI : CMD_COL_LO;
      CMD_COL_HI: nxt = ack ? RD_FB : CMD_COL_HI;
      RD_FB:      nxt = ack ? WR_LCD : RD_FB;
`ifdef PRC_COPY_CLEAR_EN
      WR_LCD:     nxt = ack ? CLR_FB : WR_LCD;
      CLR_FB:     nxt = ack ? after_data : CLR_FB;
`else
      WR_LCD:     nxt = ack ? after_data : WR_LCD;
`endif
      NEXT:       nxt = after_data;
      DONE:       nxt = IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      page <= '0;
      col <= '0;
    end else if (adv) begin
      col <= col_end ? '0 : col + 7'd1;
      page <= page + 3'(col_end);
    end
  always_comb begin
    busy = state != IDLE && state != DONE;
    done = state == DONE;
    bus.bus_request = busy;
    act = fb_acc || state inside {CMD_PAGE, CMD_COL_LO, CMD_COL_HI, WR_LCD};
    we = state != RD_FB;
    addr = fb_acc ? FB_BASE + fb_offset(page, col) : state == WR_LCD ? LCD_DATA_ADDR : LCD_CMD_ADDR;
    wdata = state == CMD_PAGE ? PAGE_CMD | {5'b0, page} :
            state == CMD_COL_LO ? COL_LO_CMD :
            state == CMD_COL_HI ? COL_HI_CMD :
            state == WR_LCD ? rdata : 8'h00;
  end
  prc_bus_cycle u_cyc (
    .clk(clk),
    .reset_n(reset_n),
    .act(act),
    .we(we),
    .grant(bus.bus_grant),
    .addr(addr),
    .wdata(wdata),
    .rdata_in(bus.data_in),
    .wr(bus.bus_write),
    .rd(bus.bus_read),
    .ack(ack),
    .addr_o(bus.address_out),
    .wdata_o(bus.data_out),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_prc_copy_engine.sv
// tb_prc_copy_engine: frame copy bench with framebuffer/LCD model, LCD write scoreboard and table of frame scenarios
module tb_prc_copy_engine;
  localparam logic [23:0] FBB = 24'h001000;
  localparam logic [23:0] CMDA = 24'h0020FE;
  localparam logic [23:0] DATA_A = 24'h0020FF;
`ifdef PRC_COPY_CLEAR_EN
  localparam int FRAME = 4656;
`else
  localparam int FRAME = 3120;
`endif
  typedef struct {
    string name;
    int drop_idx;
    int restart_at;
    logic start_on_done;
    int exp_cycles;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, busy, done;
  prc_bus_if bus();
  prc_copy_engine #(.FB_BASE(FBB), .LCD_CMD_ADDR(CMDA), .LCD_DATA_ADDR(DATA_A)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .busy(busy),
    .done(done),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, first_a = -1, last_a = -1, n_lcd = 0, n_data = 0, n_done = 0, n_strobe = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] fb [768];
  logic [31:0] exp_q [$];
  vec_t vt [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // bus slave model: framebuffer memory plus LCD registers feeding the scoreboard
  always @(negedge clk) begin
    logic strobe;
    logic [31:0] e;
    cyc++;
    strobe = bus.bus_write || bus.bus_read;
    if (strobe) begin
      n_strobe++;
      if (first_a < 0) first_a = cyc;
      last_a = cyc;
      check("strobe_shape", {prev_strobe, bus.bus_write && bus.bus_read}, 2'b00);
    end
    if (!bus.bus_grant) check("stall_strobe", strobe, 1'b0);
    prev_strobe = strobe;
    if (bus.bus_read) begin
      check("rd_range", bus.address_out >= FBB && bus.address_out < FBB + 24'd768, 1'b1);
      bus.data_in = fb[10'(bus.address_out - FBB)];
    end
    if (bus.bus_write && bus.address_out >= FBB && bus.address_out < FBB + 24'd768)
      fb[10'(bus.address_out - FBB)] = bus.data_out;
    if (bus.bus_write && (bus.address_out == CMDA || bus.address_out == DATA_A)) begin
      n_lcd++;
      if (bus.address_out == DATA_A) n_data++;
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hFFFFFFFF;
      check("lcd_seq", {bus.address_out, bus.data_out}, e);
    end
    if (done) n_done++;
  end

  task automatic init_frame();
    logic [23:0] a;
    for (int i = 0; i < 768; i++) begin
      a = FBB + 24'(i);
      fb[i] = a[7:0];
    end
    exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({CMDA, 8'hB0 | 8'(p)});
      exp_q.push_back({CMDA, 8'h00});
      exp_q.push_back({CMDA, 8'h10});
      for (int c = 0; c < 96; c++) begin
        a = FBB + 24'(p * 96 + c);
        exp_q.push_back({DATA_A, a[7:0]});
      end
    end
    first_a = -1;
    last_a = -1;
    n_lcd = 0;
    n_data = 0;
    n_done = 0;
  endtask

  task automatic fire_start();
    @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept", {busy, bus.bus_request}, 2'b11);
  endtask

  task automatic run_frame(input vec_t v);
    int k, dcnt, bad;
    logic dropped;
    logic [23:0] a;
    init_frame();
    fire_start();
    k = 0;
    dcnt = 0;
    dropped = 1'b0;
    while (n_done == 0 && k < 8000) begin
      @(posedge clk);
      #1;
      k++;
      start = (k == v.restart_at) || (v.start_on_done && done);
      if (!bus.bus_grant) begin
        if (dcnt == 0) bus.bus_grant = 1'b1;
        else dcnt--;
      end
      if (v.drop_idx > 0 && !dropped && n_data == v.drop_idx) begin
        @(negedge clk);
        #1;
        bus.bus_grant = 1'b0;
        dropped = 1'b1;
        dcnt = 10;
      end
    end
    start = 1'b0;
    bus.bus_grant = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check({v.name, "_timeout"}, n_done > 0, 1'b1);
    check({v.name, "_cycles"}, last_a - first_a + 2, v.exp_cycles);
    check({v.name, "_lcd_count"}, n_lcd, 8 * 99);
    check({v.name, "_done_pulses"}, n_done, 1);
    check({v.name, "_sb_left"}, exp_q.size(), 0);
    check({v.name, "_idle"}, {busy, bus.bus_request}, 2'b00);
    bad = 0;
    for (int i = 0; i < 768; i++) begin
      a = FBB + 24'(i);
`ifdef PRC_COPY_CLEAR_EN
      if (fb[i] !== 8'h00) bad++;
`else
      if (fb[i] !== a[7:0]) bad++;
`endif
    end
    check({v.name, "_fb_bad"}, bad, 0);
  endtask

  initial begin
    int s0;
    vt[0] = '{"plain", 0, 0, 1'b0, FRAME};
    vt[1] = '{"grant_drop", 3 * 96 + 40, 0, 1'b0, FRAME + 10};
    vt[2] = '{"restart_busy", 0, 100, 1'b0, FRAME};
    vt[3] = '{"start_on_done", 0, 0, 1'b1, FRAME};
    bus.bus_grant = 1'b1;
    bus.data_in = 8'h00;
    #3;
    check("reset_outs", {busy, done, bus.bus_request, bus.bus_write, bus.bus_read, bus.address_out, bus.data_out}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) run_frame(vt[i]);
    init_frame();
    fire_start();
    repeat (1500) @(posedge clk);
    #2;
    check("pre_reset_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_outs", {busy, done, bus.bus_request, bus.bus_write, bus.bus_read, bus.address_out, bus.data_out}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    s0 = n_strobe;
    repeat (50) @(posedge clk);
    #1;
    check("post_reset_quiet", {n_strobe - s0, 30'(busy), bus.bus_request}, 0);
    run_frame(vt[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
